// File: rtl/y86_pkg.sv
// ============================================================================
// Module : y86_pkg
// Brief  : Shared Y86-64 fetch constants: icodes, status codes, FSM states.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DONE   = 2'd2,
        HALTED = 2'd3
    } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/instr_len_decode.sv
// ============================================================================
// Module : instr_len_decode
// Brief  : Combinational icode -> length / field-presence decoder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_len_decode
    import y86_pkg::*;
(
    input  logic [3:0] icode_i,
    output logic [3:0] len_o,
    output logic       need_regids_o,
    output logic       need_valc_o,
    output logic [3:0] valc_offset_o,
    output logic       icode_ok_o
);

    always_comb begin
        len_o         = 4'd1;
        need_regids_o = 1'b0;
        need_valc_o   = 1'b0;
        valc_offset_o = 4'd0;
        icode_ok_o    = 1'b1;
        case (icode_i)
            I_HALT, I_NOP, I_RET: begin
                len_o = 4'd1;
            end
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
                len_o         = 4'd2;
                need_regids_o = 1'b1;
            end
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                len_o         = 4'd10;
                need_regids_o = 1'b1;
                need_valc_o   = 1'b1;
                valc_offset_o = 4'd2;
            end
            I_JXX, I_CALL: begin
                len_o         = 4'd9;
                need_valc_o   = 1'b1;
                valc_offset_o = 4'd1;
            end
            // Unknown opcodes occupy a single byte so the fetch stops early.
            default: begin
                len_o      = 4'd1;
                icode_ok_o = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module : fetch_unit
// Brief  : Sequential Y86-64 fetch stage; byte-serial imem reads and decode.
//          Optional macro FETCH_PERF_EN adds instruction/stall counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_unit
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned MAX_LEN  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] pc_next,
    input  logic        pc_next_valid,
    output logic        pc_next_ready,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic [7:0]  imem_data,
    input  logic        imem_err,
    output logic        instr_valid,
    input  logic        instr_ready,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_instr_count,
    output logic [31:0] perf_stall_cycles,
`endif
    output logic [63:0] pc,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic [1:0]  stat
);

    localparam int IDX_W = $clog2(MAX_LEN + 1);

    fetch_state_e     state_q, state_d;
    logic [63:0]      pc_q, pc_d;
    logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic [3:0]       icode_q, icode_d;
    logic [3:0]       ifun_q, ifun_d;
    logic [3:0]       ra_q, ra_d;
    logic [3:0]       rb_q, rb_d;
    logic [63:0]      valc_q, valc_d;
    logic [63:0]      valp_q, valp_d;
    logic [1:0]       stat_q, stat_d;

    logic [3:0]       dec_icode;
    logic [3:0]       dec_len;
    logic             dec_need_regids;
    logic             dec_need_valc;
    logic [3:0]       dec_valc_off;
    logic             dec_ok;
    logic [IDX_W-1:0] idx_inc;
    logic [2:0]       valc_sel;

    // On byte 0 the icode register is not yet loaded, so decode straight
    // from the incoming byte; afterwards use the captured icode.
    assign dec_icode = (byte_idx_q == '0) ? imem_data[7:4] : icode_q;

    instr_len_decode u_len_decode (
        .icode_i       (dec_icode),
        .len_o         (dec_len),
        .need_regids_o (dec_need_regids),
        .need_valc_o   (dec_need_valc),
        .valc_offset_o (dec_valc_off),
        .icode_ok_o    (dec_ok)
    );

    assign idx_inc  = byte_idx_q + IDX_W'(1);
    assign valc_sel = 3'(byte_idx_q - IDX_W'(dec_valc_off));

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        byte_idx_d = byte_idx_q;
        icode_d    = icode_q;
        ifun_d     = ifun_q;
        ra_d       = ra_q;
        rb_d       = rb_q;
        valc_d     = valc_q;
        valp_d     = valp_q;
        stat_d     = stat_q;
        case (state_q)
            IDLE: begin
                if (pc_next_valid) begin
                    state_d    = FETCH;
                    pc_d       = pc_next;
                    byte_idx_d = '0;
                    icode_d    = 4'h0;
                    ifun_d     = 4'h0;
                    ra_d       = REG_NONE;
                    rb_d       = REG_NONE;
                    valc_d     = 64'h0;
                    valp_d     = 64'h0;
                    stat_d     = STAT_AOK;
                end
            end
            FETCH: begin
                if (imem_ready) begin
                    byte_idx_d = idx_inc;
                    if (imem_err) begin
                        state_d = DONE;
                        stat_d  = STAT_ADR;
                        if (byte_idx_q == '0) begin
                            valp_d = pc_q + 64'd1;
                        end
                    end else begin
                        if (byte_idx_q == '0) begin
                            icode_d = imem_data[7:4];
                            ifun_d  = imem_data[3:0];
                            valp_d  = pc_q + 64'(dec_len);
                            if (!dec_ok) begin
                                stat_d = STAT_INS;
                            end else if (imem_data[7:4] == I_HALT) begin
                                stat_d = STAT_HLT;
                            end
                        end else if (byte_idx_q == IDX_W'(1) && dec_need_regids) begin
                            ra_d = imem_data[7:4];
                            rb_d = imem_data[3:0];
                        end
                        // valC is little-endian: byte k of the constant lands in bits 8k+:8.
                        if (dec_need_valc && (byte_idx_q >= IDX_W'(dec_valc_off))) begin
                            valc_d[{valc_sel, 3'b000} +: 8] = imem_data;
                        end
                        if (idx_inc == IDX_W'(dec_len)) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                if (instr_ready) begin
                    state_d = (stat_q == STAT_AOK) ? IDLE : HALTED;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            byte_idx_q <= '0;
            icode_q    <= 4'h0;
            ifun_q     <= 4'h0;
            ra_q       <= REG_NONE;
            rb_q       <= REG_NONE;
            valc_q     <= 64'h0;
            valp_q     <= 64'h0;
            stat_q     <= STAT_AOK;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            byte_idx_q <= byte_idx_d;
            icode_q    <= icode_d;
            ifun_q     <= ifun_d;
            ra_q       <= ra_d;
            rb_q       <= rb_d;
            valc_q     <= valc_d;
            valp_q     <= valp_d;
            stat_q     <= stat_d;
        end
    end

    assign pc_next_ready = (state_q == IDLE);
    assign imem_req      = (state_q == FETCH);
    assign imem_addr     = pc_q + 64'(byte_idx_q);
    assign instr_valid   = (state_q == DONE);
    assign pc            = pc_q;
    assign icode         = icode_q;
    assign ifun          = ifun_q;
    assign rA            = ra_q;
    assign rB            = rb_q;
    assign valC          = valc_q;
    assign valP          = valp_q;
    assign stat          = stat_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_instr_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_instr_q <= 32'h0;
            perf_stall_q <= 32'h0;
        end else begin
            if (instr_valid && instr_ready && (perf_instr_q != 32'hFFFF_FFFF)) begin
                perf_instr_q <= perf_instr_q + 32'd1;
            end
            if (imem_req && !imem_ready && (perf_stall_q != 32'hFFFF_FFFF)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_instr_count  = perf_instr_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module : tb_fetch_unit
// Brief  : Randomized scoreboard bench for fetch_unit with a byte-level memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    localparam logic [63:0] C_RESET_PC = 64'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] pc_next;
    logic        pc_next_valid;
    logic        pc_next_ready;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic [7:0]  imem_data;
    logic        imem_err;
    logic        instr_valid;
    logic        instr_ready;
    logic [63:0] pc;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP;
    logic [1:0]  stat;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_instr_count, perf_stall_cycles;
`endif

    fetch_unit #(.RESET_PC(C_RESET_PC), .MAX_LEN(10)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_next       (pc_next),
        .pc_next_valid (pc_next_valid),
        .pc_next_ready (pc_next_ready),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_data     (imem_data),
        .imem_err      (imem_err),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
`ifdef FETCH_PERF_EN
        .perf_instr_count  (perf_instr_count),
        .perf_stall_cycles (perf_stall_cycles),
`endif
        .pc            (pc),
        .icode         (icode),
        .ifun          (ifun),
        .rA            (rA),
        .rB            (rB),
        .valC          (valC),
        .valP          (valP),
        .stat          (stat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp;
        logic [1:0]  stat;
        bit          chk_valp;
        int          nreq;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          hs_cnt   = 0;

    // Memory image for the instruction currently being fetched.
    logic [63:0] cur_base = 64'h0;
    logic [7:0]  cur_bytes [10];
    int          cur_err  = -1;
    int          cur_mode = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int len_of(input int ic);
        case (ic)
            0, 1, 9:        return 1;
            2, 6, 10, 11:   return 2;
            7, 8:           return 9;
            3, 4, 5:        return 10;
            default:        return 1;
        endcase
    endfunction

    // Memory responder: ready pattern by mode, data/err from the image.
    logic [63:0] rsp_off;
    initial begin
        imem_ready  = 1'b0;
        imem_data   = 8'h00;
        imem_err    = 1'b0;
        instr_ready = 1'b0;
        forever begin
            @(negedge clk);
            rsp_off = imem_addr - cur_base;
            case (cur_mode)
                0:       imem_ready = 1'b1;
                1:       imem_ready = ~imem_ready;
                default: imem_ready = 1'($urandom_range(0, 1));
            endcase
            imem_data   = (rsp_off < 64'd10) ? cur_bytes[rsp_off[3:0]] : 8'h00;
            imem_err    = (cur_err >= 0) && (rsp_off == 64'(cur_err));
            instr_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: address stability, request counting, latency, scoreboard pops.
    initial begin
        int          nreq_cnt;
        int          cyc;
        int          lat_obs;
        bit          lat_pending;
        bit          prev_stall;
        logic [63:0] prev_addr;
        exp_t        e;
        nreq_cnt = 0; cyc = 0; lat_obs = -1; lat_pending = 0;
        prev_stall = 0; prev_addr = 64'h0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                prev_stall  = 0;
                lat_pending = 0;
                continue;
            end
            if (prev_stall) begin
                chk("addr_stable", imem_addr, prev_addr);
                chk("req_held", 64'(imem_req), 64'd1);
            end
            prev_stall = imem_req && !imem_ready;
            prev_addr  = imem_addr;
            if (pc_next_valid && pc_next_ready) begin
                nreq_cnt = 0; cyc = 0; lat_obs = -1; lat_pending = 1;
            end else begin
                cyc++;
                if (imem_req && imem_ready) nreq_cnt++;
                if (lat_pending && instr_valid) begin
                    lat_obs     = cyc;
                    lat_pending = 0;
                end
            end
            if (instr_valid && instr_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_instr: got pc %h expected none", pc);
                end else begin
                    e = sb_q.pop_front();
                    chk("pc", pc, e.pc);
                    chk("icode", 64'(icode), 64'(e.icode));
                    chk("ifun", 64'(ifun), 64'(e.ifun));
                    chk("rA", 64'(rA), 64'(e.ra));
                    chk("rB", 64'(rB), 64'(e.rb));
                    chk("valC", valC, e.valc);
                    chk("stat", 64'(stat), 64'(e.stat));
                    if (e.chk_valp) chk("valP", valP, e.valp);
                    chk("nreq", 64'(nreq_cnt), 64'(e.nreq));
                    if (e.lat > 0) chk("latency", 64'(lat_obs), 64'(e.lat));
                end
                hs_cnt++;
            end
        end
    end

    task automatic do_reset();
        pc_next_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        sb_q.delete();
    endtask

    // Issue one instruction (image already in cur_bytes) and wait for it.
    task automatic issue(input logic [63:0] ipc, input int err, input int mode);
        exp_t e;
        int   ic, len, k, off, hs0, t;
        ic  = int'(cur_bytes[0][7:4]);
        len = len_of(ic);
        k   = (err >= 0) ? err : len;
        e.pc   = ipc;
        e.icode = (k > 0) ? cur_bytes[0][7:4] : 4'h0;
        e.ifun  = (k > 0) ? cur_bytes[0][3:0] : 4'h0;
        e.ra = 4'hF;
        e.rb = 4'hF;
        if (k > 1 && (ic inside {2, 3, 4, 5, 6, 10, 11})) begin
            e.ra = cur_bytes[1][7:4];
            e.rb = cur_bytes[1][3:0];
        end
        off = (ic inside {3, 4, 5}) ? 2 : ((ic inside {7, 8}) ? 1 : 0);
        e.valc = 64'h0;
        if (off > 0)
            for (int j = 0; j < 8; j++)
                if (off + j < k) e.valc = e.valc | (64'(cur_bytes[off + j]) << (8 * j));
        if (err >= 0)     e.stat = 2'd2;
        else if (ic == 0) e.stat = 2'd1;
        else if (ic > 11) e.stat = 2'd3;
        else              e.stat = 2'd0;
        e.valp     = ipc + 64'(len);
        e.chk_valp = (k > 0);
        e.nreq     = (err >= 0) ? err + 1 : len;
        e.lat      = (mode == 0) ? e.nreq + 1 : 0;

        @(negedge clk);
        cur_base = ipc;
        cur_err  = err;
        cur_mode = mode;
        t = 0;
        while (!pc_next_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!pc_next_ready) begin
            n_checks++; n_fail++;
            $display("FAIL pc_next_ready_timeout: got 0 expected 1");
            do_reset();
            return;
        end
        sb_q.push_back(e);
        hs0 = hs_cnt;
        pc_next       = ipc;
        pc_next_valid = 1'b1;
        @(negedge clk);
        pc_next_valid = 1'b0;
        t = 0;
        // Random pc_next noise while busy must be ignored.
        forever begin
            @(negedge clk);
            if (hs_cnt != hs0 || t >= 400) break;
            pc_next_valid = 1'($urandom_range(0, 1));
            pc_next       = {$urandom, $urandom};
            t++;
        end
        pc_next_valid = 1'b0;
        if (hs_cnt == hs0) begin
            n_checks++; n_fail++;
            $display("FAIL handshake_timeout: got none expected instr at %h", ipc);
            do_reset();
            return;
        end
        #1;
        if (e.stat == 2'd0) begin
            chk("ready_after_hs", 64'(pc_next_ready), 64'd1);
        end else begin
            for (int c = 0; c < 4; c++) begin
                pc_next_valid = 1'b1;
                pc_next       = {$urandom, $urandom};
                chk("halted_ready", 64'(pc_next_ready), 64'd0);
                chk("halted_req", 64'(imem_req), 64'd0);
                chk("halted_valid", 64'(instr_valid), 64'd0);
                @(negedge clk);
                #1;
            end
            do_reset();
        end
    endtask

    task automatic set_bytes(input logic [79:0] img);
        for (int j = 0; j < 10; j++) cur_bytes[j] = img[79 - 8*j -: 8];
    endtask

    initial begin
        reset         = 1'b1;
        pc_next       = 64'h0;
        pc_next_valid = 1'b0;
        for (int j = 0; j < 10; j++) cur_bytes[j] = 8'h00;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_pc", pc, C_RESET_PC);
        chk("rst_ready", 64'(pc_next_ready), 64'd1);
        chk("rst_req", 64'(imem_req), 64'd0);
        chk("rst_addr", imem_addr, C_RESET_PC);
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_rA", 64'(rA), 64'hF);
        chk("rst_rB", 64'(rB), 64'hF);
        chk("rst_icode", 64'(icode), 64'd0);
        chk("rst_valC", valC, 64'd0);
        chk("rst_valP", valP, 64'd0);
        chk("rst_stat", 64'(stat), 64'd0);
        reset = 1'b0;

        set_bytes(80'h30F2_0A00_0000_0000_0000);     // irmovq $10, %rdx
        issue(64'h100, -1, 0);
        set_bytes(80'h9000_0000_0000_0000_0000);     // ret
        issue(64'h40, -1, 2);
        set_bytes(80'h7334_1200_0000_0000_0000);     // jXX 0x1234
        issue(64'h0, -1, 1);
        set_bytes(80'h30F2_0A00_0000_0000_0000);     // valP and addresses wrap
        issue(64'hFFFF_FFFF_FFFF_FFFA, -1, 0);
        set_bytes(80'h4012_8877_6655_4433_2211);     // rmmovq, error on byte 3
        issue(64'h300, 3, 0);
        set_bytes(80'hC000_0000_0000_0000_0000);     // invalid icode
        issue(64'h500, -1, 0);

        for (int n = 0; n < 40; n++) begin
            int          ic, len, err, mode;
            logic [63:0] ipc;
            ic = int'($urandom_range(0, 15));
            if ((ic == 0 || ic > 11) && $urandom_range(0, 2) != 0) ic = int'($urandom_range(1, 11));
            for (int j = 0; j < 10; j++) cur_bytes[j] = 8'($urandom);
            cur_bytes[0][7:4] = 4'(ic);
            len = len_of(ic);
            if ($urandom_range(0, 4) == 0) err = int'($urandom_range(0, len - 1));
            else                           err = -1;
            mode = int'($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0) ipc = 64'hFFFF_FFFF_FFFF_FFF8;
            else                           ipc = {$urandom, $urandom};
            issue(ipc, err, mode);
        end

        // Reset in the middle of a 10-byte fetch discards the instruction.
        set_bytes(80'h5034_0100_0000_0000_0000);
        @(negedge clk);
        cur_base = 64'h700; cur_err = -1; cur_mode = 0;
        pc_next = 64'h700; pc_next_valid = 1'b1;
        @(negedge clk);
        pc_next_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("midfetch_req", 64'(imem_req), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("rstmid_req", 64'(imem_req), 64'd0);
        chk("rstmid_pc", pc, C_RESET_PC);
        chk("rstmid_ready", 64'(pc_next_ready), 64'd1);
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            #1;
            chk("rstmid_no_valid", 64'(instr_valid), 64'd0);
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
